// File: rtl/bus_arbiter.sv
// Three-requester arbiter feeding a single downstream bus channel with one
// outstanding transaction; round-robin or fixed-priority grant, writes before reads.
module bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      req_rd,
  input  logic [3*AW-1:0] req_rd_addr,
  input  logic [2:0]      req_wr,
  input  logic [11:0]     req_wstrb,
  input  logic [3*AW-1:0] req_wr_addr,
  input  logic [3*DW-1:0] req_wdata,
  output logic [2:0]      req_reload,
  output logic [DW-1:0]   req_rd_data,
  output logic            bus_rd_req,
  output logic [AW-1:0]   bus_rd_addr,
  output logic            bus_wr_req,
  output logic [3:0]      bus_wr_wstrb,
  output logic [AW-1:0]   bus_wr_addr,
  output logic [DW-1:0]   bus_wr_data,
  input  logic            bus_reload,
  input  logic [DW-1:0]   bus_rd_data,
  output logic            fsm_busy
);

  // Handshake: a grant launches one bus request that is held unchanged until
  // bus_reload is seen in BUSY; that same cycle pulses req_reload for the owner.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_next;
  logic [1:0]  id;
  logic [1:0]  rr_ptr;
  logic [1:0]  win;
  logic        win_valid;
  logic        win_wr;
  logic [2:0]  cand;
  logic        grant;
  logic        done;

  function automatic logic [1:0] first_of(input logic [2:0] c, input logic [1:0] a,
                                          input logic [1:0] b, input logic [1:0] d);
    if (c[a]) return a;
    else if (c[b]) return b;
    else return d;
  endfunction

  assign cand = req_rd | req_wr;

  always_comb begin
    win_valid = |cand;
    win       = first_of(cand, 2'd0, 2'd1, 2'd2);
    if (FIXED_PRIO == 0) begin
      case (rr_ptr)
        2'd1:    win = first_of(cand, 2'd1, 2'd2, 2'd0);
        2'd2:    win = first_of(cand, 2'd2, 2'd0, 2'd1);
        default: win = first_of(cand, 2'd0, 2'd1, 2'd2);
      endcase
    end
    win_wr = req_wr[win];
  end

  assign grant = (state == IDLE) && win_valid;
  assign done  = (state == BUSY) && bus_reload;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid)  state_next = BUSY;
      BUSY:    if (bus_reload) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_reload = 3'b000;
    if (state == BUSY && bus_reload) req_reload[id] = 1'b1;
    req_rd_data = resetn ? bus_rd_data : '0;
    fsm_busy    = (state == BUSY);
  end

  // Bus fields load only on a grant and clear only on completion, so they
  // stay frozen through BUSY regardless of requester activity.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id           <= 2'd0;
      rr_ptr       <= 2'd0;
      bus_rd_req   <= 1'b0;
      bus_rd_addr  <= '0;
      bus_wr_req   <= 1'b0;
      bus_wr_wstrb <= 4'b0;
      bus_wr_addr  <= '0;
      bus_wr_data  <= '0;
    end else if (grant) begin
      id <= win;
      if (win_wr) begin
        bus_wr_req   <= 1'b1;
        bus_wr_wstrb <= req_wstrb[int'(win)*4 +: 4];
        bus_wr_addr  <= req_wr_addr[int'(win)*AW +: AW];
        bus_wr_data  <= req_wdata[int'(win)*DW +: DW];
        bus_rd_req   <= 1'b0;
        bus_rd_addr  <= '0;
      end else begin
        bus_rd_req   <= 1'b1;
        bus_rd_addr  <= req_rd_addr[int'(win)*AW +: AW];
        bus_wr_req   <= 1'b0;
        bus_wr_wstrb <= 4'b0;
        bus_wr_addr  <= '0;
        bus_wr_data  <= '0;
      end
    end else if (done) begin
      rr_ptr       <= (id == 2'd2) ? 2'd0 : id + 2'd1;
      bus_rd_req   <= 1'b0;
      bus_rd_addr  <= '0;
      bus_wr_req   <= 1'b0;
      bus_wr_wstrb <= 4'b0;
      bus_wr_addr  <= '0;
      bus_wr_data  <= '0;
    end
  end

endmodule
